// File: rtl/sonic_irq_pkg.sv
// sonic_irq_pkg: FSM states and DW0 field layout for the SoNIC interrupt generator
package sonic_irq_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_e;
    localparam int IRQ_EN_BIT   = 0;
    localparam int CLR_PEND_BIT = 1;
    localparam int MSI_NUM_LSB  = 4;
    localparam int MSI_NUM_MSB  = 8;
    localparam int COALESCE_LSB = 16;
    localparam int COALESCE_MSB = 31;
endpackage

// File: rtl/sonic_constants.sv
// sonic_constants: SoNIC control register addresses shared by the command path and IRQ generator
`ifndef SONIC_REG_CNTL_DW0
`define SONIC_REG_CNTL_DW0 8'h00
`define SONIC_REG_CNTL_DW1 8'h04
`define SONIC_REG_CNTL_DW2 8'h08
`define SONIC_REG_CNTL_DW3 8'h0C
`define SONIC_REG_CNTL_DW4 8'h10
`define SONIC_REG_CNTL_DW5 8'h14
`endif

// File: rtl/sonic_irq_blk_counter.sv
// sonic_irq_blk_counter: groups RX words into blocks, tracks pending and total block counts
// Ports: clk_in/rstn (sync active-low), word_valid_i (one per 128-bit word),
//        blk_size_i (words per block, 0 disables), size_wr_i (restart current block),
//        dec_i/dec_amt_i (consume pending blocks), clr_i (drop all pending),
//        pend_o (saturating pending blocks), block_seq_o (wrapping completed blocks)
module sonic_irq_blk_counter
    import sonic_irq_pkg::*;
#(
    parameter int PEND_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rstn,
    input  logic                  word_valid_i,
    input  logic [31:0]           blk_size_i,
    input  logic                  size_wr_i,
    input  logic                  dec_i,
    input  logic [15:0]           dec_amt_i,
    input  logic                  clr_i,
    output logic [PEND_WIDTH-1:0] pend_o,
    output logic [31:0]           block_seq_o
);
    logic [31:0]           word_cnt_q, word_cnt_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d, pend_inc;
    logic [31:0]           seq_q;
    logic                  done;
    assign done = word_valid_i && blk_size_i != 32'd0 && word_cnt_q == blk_size_i - 32'd1;
    always_comb begin
        word_cnt_d = size_wr_i ? 32'd0 :
                     (word_valid_i && blk_size_i != 32'd0) ? (done ? 32'd0 : word_cnt_q + 32'd1) :
                     word_cnt_q;
        // increment first, then consume, then clear: clear discards a same-cycle completion
        pend_inc = (done && !(&pend_q)) ? pend_q + 1'b1 : pend_q;
        pend_d = !dec_i ? pend_inc :
                 (32'(pend_inc) >= 32'(dec_amt_i)) ? PEND_WIDTH'(32'(pend_inc) - 32'(dec_amt_i)) : '0;
        pend_d = clr_i ? '0 : pend_d;
    end
    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            word_cnt_q <= '0;
            pend_q     <= '0;
            seq_q      <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            pend_q     <= pend_d;
            seq_q      <= seq_q + 32'(done);
        end
    end
    assign pend_o      = pend_q;
    assign block_seq_o = seq_q;
endmodule

// File: rtl/sonic_irq_gen.sv
// sonic_irq_gen: IRQ register file, RX block coalescing and MSI request generation for SoNIC
// Ports: clk_in/rstn (sync active-low); irq_prg_wrena/wrdata/addr write the DW0..DW3 registers,
//        irq_prg_rddata is the registered readback; rx_word_valid counts RX ring words;
//        rx_block_size/irq_wb_addr export DW3 and {DW2,DW1}; block_seq counts completed blocks;
//        app_msi_req/ack/num form the MSI handshake; irq_busy is high outside IDLE.
// Build option: SONIC_IRQ_STATS_EN adds irq_sent (DW4) and pend_max (DW5) readback.
`ifndef SONIC_REG_CNTL_DW0
`define SONIC_REG_CNTL_DW0 8'h00
`define SONIC_REG_CNTL_DW1 8'h04
`define SONIC_REG_CNTL_DW2 8'h08
`define SONIC_REG_CNTL_DW3 8'h0C
`define SONIC_REG_CNTL_DW4 8'h10
`define SONIC_REG_CNTL_DW5 8'h14
`endif
module sonic_irq_gen
    import sonic_irq_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 64,
    parameter int PEND_WIDTH     = 16
) (
    input  logic        clk_in,
    input  logic        rstn,
    input  logic        irq_prg_wrena,
    input  logic [31:0] irq_prg_wrdata,
    input  logic [7:0]  irq_prg_addr,
    output logic [31:0] irq_prg_rddata,
    input  logic        rx_word_valid,
    output logic [31:0] rx_block_size,
    output logic [63:0] irq_wb_addr,
    output logic [31:0] block_seq,
    output logic        app_msi_req,
    input  logic        app_msi_ack,
    output logic [4:0]  app_msi_num,
    output logic        irq_busy
);
    logic                  irq_en_q;
    logic [4:0]            msi_num_q, req_num_q, req_num_d;
    logic [15:0]           coalesce_q, coal_eff;
    logic [31:0]           wb_lo_q, wb_hi_q, blk_size_q, rddata_q, rd_d, stats_rd, hold_cnt_q, hold_cnt_d;
    irq_state_e            state_q, state_d;
    logic [PEND_WIDTH-1:0] pend;
    logic                  wr_dw0, clr_pend, msi_acc, unused_wrdata;
    assign wr_dw0        = irq_prg_wrena && irq_prg_addr == `SONIC_REG_CNTL_DW0;
    assign clr_pend      = wr_dw0 && irq_prg_wrdata[CLR_PEND_BIT];
    assign coal_eff      = (coalesce_q == 16'd0) ? 16'd1 : coalesce_q;
    assign msi_acc       = state_q == REQ && app_msi_ack;
    assign unused_wrdata = ^{irq_prg_wrdata[15:9], irq_prg_wrdata[3:2]};
    sonic_irq_blk_counter #(.PEND_WIDTH(PEND_WIDTH)) u_cnt (
        .clk_in      (clk_in),
        .rstn        (rstn),
        .word_valid_i(rx_word_valid),
        .blk_size_i  (blk_size_q),
        .size_wr_i   (irq_prg_wrena && irq_prg_addr == `SONIC_REG_CNTL_DW3),
        .dec_i       (msi_acc),
        .dec_amt_i   (coal_eff),
        .clr_i       (clr_pend),
        .pend_o      (pend),
        .block_seq_o (block_seq)
    );
`ifdef SONIC_IRQ_STATS_EN
    logic [31:0] irq_sent_q;
    logic [15:0] pend_max_q;
    always_ff @(posedge clk_in) begin
        if (!rstn || clr_pend) begin
            irq_sent_q <= '0;
            pend_max_q <= '0;
        end else begin
            irq_sent_q <= irq_sent_q + 32'(msi_acc);
            pend_max_q <= (16'(pend) > pend_max_q) ? 16'(pend) : pend_max_q;
        end
    end
    assign stats_rd = (irq_prg_addr == `SONIC_REG_CNTL_DW4) ? irq_sent_q :
                      (irq_prg_addr == `SONIC_REG_CNTL_DW5) ? {16'h0, pend_max_q} : 32'd0;
`else
    assign stats_rd = 32'd0;
`endif
    assign rd_d = (irq_prg_addr == `SONIC_REG_CNTL_DW0) ? {coalesce_q, 7'd0, msi_num_q, 3'd0, irq_en_q} :
                  (irq_prg_addr == `SONIC_REG_CNTL_DW1) ? wb_lo_q :
                  (irq_prg_addr == `SONIC_REG_CNTL_DW2) ? wb_hi_q :
                  (irq_prg_addr == `SONIC_REG_CNTL_DW3) ? blk_size_q : stats_rd;
    // the vector is captured on entry to REQ so DW0 writes cannot disturb a request in flight
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        req_num_d  = req_num_q;
        unique case (state_q)
            IDLE: if (irq_en_q && 32'(pend) >= 32'(coal_eff)) begin
                state_d   = REQ;
                req_num_d = msi_num_q;
            end
            REQ: if (app_msi_ack) begin
                state_d    = HOLDOFF;
                hold_cnt_d = '0;
            end
            HOLDOFF: begin
                state_d    = (hold_cnt_q + 32'd1 >= 32'(HOLDOFF_CYCLES)) ? IDLE : HOLDOFF;
                hold_cnt_d = hold_cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            irq_en_q   <= 1'b0;
            msi_num_q  <= '0;
            coalesce_q <= '0;
            wb_lo_q    <= '0;
            wb_hi_q    <= '0;
            blk_size_q <= '0;
            rddata_q   <= '0;
            req_num_q  <= '0;
            hold_cnt_q <= '0;
            state_q    <= IDLE;
        end else begin
            if (wr_dw0) begin
                irq_en_q   <= irq_prg_wrdata[IRQ_EN_BIT];
                msi_num_q  <= irq_prg_wrdata[MSI_NUM_MSB:MSI_NUM_LSB];
                coalesce_q <= irq_prg_wrdata[COALESCE_MSB:COALESCE_LSB];
            end
            if (irq_prg_wrena && irq_prg_addr == `SONIC_REG_CNTL_DW1) wb_lo_q <= irq_prg_wrdata;
            if (irq_prg_wrena && irq_prg_addr == `SONIC_REG_CNTL_DW2) wb_hi_q <= irq_prg_wrdata;
            if (irq_prg_wrena && irq_prg_addr == `SONIC_REG_CNTL_DW3) blk_size_q <= irq_prg_wrdata;
            rddata_q   <= rd_d;
            req_num_q  <= req_num_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
        end
    end
    assign irq_prg_rddata = rddata_q;
    assign rx_block_size  = blk_size_q;
    assign irq_wb_addr    = {wb_hi_q, wb_lo_q};
    assign app_msi_req    = state_q == REQ;
    assign app_msi_num    = req_num_q;
    assign irq_busy       = state_q != IDLE;
endmodule

// File: doc/sonic_irq_gen.md
Name: sonic_irq_gen

Overview:
- Interrupt generator that sits directly downstream of the SoNIC command controller.
- Owns the IRQ register file, which the controller writes via irq_prg_*: IRQ config, writeback address, RX block size.
- Counts 128-bit words landing in the RX ring, groups them into blocks, coalesces blocks and raises MSI requests to the PCIe hard IP.
- Exports rx_block_size back to the command controller and the writeback address to the RC update logic.

Parameters:
- HOLDOFF_CYCLES, 64, minimum idle cycles between two MSI requests.
- PEND_WIDTH, 16, width of the pending-block counter.

Ports:
- clk_in  in  1  clock
- rstn  in  1  synchronous active-low reset
- irq_prg_wrena  in  1  register write strobe
- irq_prg_wrdata  in  32  register write data
- irq_prg_addr  in  8  register address (`SONIC_REG_CNTL_DW0..DW3`)
- irq_prg_rddata  out  32  registered readback of irq_prg_addr
- rx_word_valid  in  1  one pulse per 128-bit word written to RX ring
- rx_block_size  out  32  DW3 value, in 128-bit words
- irq_wb_addr  out  64  {DW2,DW1}, RC writeback address
- block_seq  out  32  total completed blocks, wraps at 2^32
- app_msi_req  out  1  MSI request to hard IP
- app_msi_ack  in  1  MSI acknowledge
- app_msi_num  out  5  MSI vector
- irq_busy  out  1  high when FSM is not IDLE

Behaviour:
- Reset (rstn=0 sampled at clk_in edge): all registers 0, word_cnt=0, pend=0, FSM=IDLE, all outputs 0.
- Reset mid-request drops app_msi_req next cycle; a late ack is ignored.
- Register map:
  - DW0: [0] irq_en; [1] clr_pend (write-1 self-clearing, reads 0); [8:4] msi_num; [31:16] coalesce (0 treated as 1).
  - DW1: address low.
  - DW2: address high.
  - DW3: block size.
  - Writes take effect the cycle after wrena.
  - irq_prg_rddata updates one cycle after the address changes.
  - Unmapped addresses read 0.
- Block counting:
  - Only when DW3!=0; with DW3=0, rx_word_valid is ignored.
  - On rx_word_valid: if word_cnt==DW3-1, word_cnt<=0, pend++ (saturating at all-ones) and block_seq++; else word_cnt++.
  - Any write to DW3 clears word_cnt; pend and block_seq are kept.
- FSM states IDLE, REQ, HOLDOFF:
  - IDLE->REQ when irq_en && pend>=coalesce.
  - REQ: app_msi_req=1 and app_msi_num=msi_num, both held stable until app_msi_ack. On the ack cycle, pend<=pend-coalesce (+1 if a block completes the same cycle); go to HOLDOFF.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles, then IDLE.
  - irq_en cleared during REQ: request still held until ack (MSI rule); the next request is suppressed.
  - msi_num write during REQ: takes effect on the next request only.
- clr_pend: pend<=0, applied after any same-cycle increment, so a simultaneous block completion is discarded. A clr_pend in REQ does not withdraw the request; decrement saturates at 0.
- irq_wb_addr and rx_block_size are combinational from the registers.

Optional Feature:
- SONIC_IRQ_STATS_EN defined:
  - Adds a 32-bit irq_sent counter, incremented on each app_msi_ack accepted in REQ.
  - Adds a 16-bit pend_max high-water mark.
  - Readable at `SONIC_REG_CNTL_DW4` as irq_sent and at `SONIC_REG_CNTL_DW5` as {16'h0,pend_max}.
  - Both cleared by reset and by clr_pend.
- Undefined: no counters; DW4/DW5 read 0.

Decomposition:
- Package sonic_irq_pkg:
  - FSM enum (IDLE=0, REQ=1, HOLDOFF=2).
  - DW0 field positions/widths (IRQ_EN_BIT, CLR_PEND_BIT, MSI_NUM_LSB/MSB, COALESCE_LSB/MSB).
- Register address macros stay in sonic_constants.sv.
- One sub-module: sonic_irq_blk_counter. It contains word_cnt, pend and block_seq. Inputs: rx_word_valid, block size, size_wr, dec, dec_amt, clr. Outputs: pend, block_seq.

Test Plan:
- Reset, read DW0..DW3 -> all 0; app_msi_req=0; rx_block_size=0.
- DW3=4, DW0={coalesce=1,msi_num=3,irq_en=1}, 8 rx_word_valid pulses, ack 2 cycles after each req -> two MSI requests with app_msi_num=3, separated by >=HOLDOFF_CYCLES; block_seq=2; pend=0.
- DW3=2, coalesce=3, 10 words -> exactly one request at block 3; pend=2 after ack; block_seq=5.
- Ack withheld 20 cycles while irq_en cleared at cycle 5 -> req stays high until ack, then no further request despite pend>0.
- Block completes on the same cycle as app_msi_ack (coalesce=1, pend=1) -> pend=1 afterwards. Block completes on the same cycle as clr_pend -> pend=0.
- DW3 rewritten after 3 of 4 words, then 4 more words -> exactly one block counted. With SONIC_IRQ_STATS_EN, DW4 read equals number of acks (e.g. 2).
